// File: rtl/mod_sequencer.sv
// Modulator datapath controller: symbol strobe generation and
// FILL/RUN/DRAIN sequencing of the PRBS and FIR enables.
module mod_sequencer #(
   parameter int NB_COUNT     = 3,
   parameter int NB_BURST     = 16,
   parameter int FILL_SYMBOLS = 6
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic [NB_BURST-1:0] i_burst_len,
   output logic                o_valid,
   output logic                o_prbs_enable,
   output logic                o_fir_enable,
   output logic                o_out_valid,
   output logic                o_busy,
   output logic                o_done,
   output logic [1:0]          o_state,
   output logic [NB_BURST-1:0] o_sym_count
);

   localparam int NB_FILL =
      (FILL_SYMBOLS > 1) ? $clog2(FILL_SYMBOLS) : 1;
   localparam logic [NB_FILL-1:0] FILL_LAST =
      NB_FILL'(FILL_SYMBOLS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t              state;
   logic [NB_COUNT-1:0] phase;
   logic [NB_FILL-1:0]  fill_cnt;
   logic [NB_BURST-1:0] sym_count;
   logic                done;
   logic                strobe;
   logic [NB_BURST-1:0] sym_next;
   logic                burst_hit;

   assign strobe    = (state != IDLE) && (&phase);
   assign sym_next  = sym_count + NB_BURST'(1);
   assign burst_hit = strobe && (i_burst_len != '0)
                      && (sym_next == i_burst_len);

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state     <= IDLE;
         phase     <= '0;
         fill_cnt  <= '0;
         sym_count <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               phase <= '0;
               if (i_start && !i_stop) begin
                  state     <= FILL;
                  sym_count <= '0;
                  fill_cnt  <= '0;
               end
            end
            FILL: begin
               phase <= phase + 1'b1;
               if (i_stop) begin
                  state <= IDLE;
                  phase <= '0;
               end else if (strobe) begin
                  if (fill_cnt == FILL_LAST) begin
                     state    <= RUN;
                     fill_cnt <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               phase <= phase + 1'b1;
               if (strobe)
                  sym_count <= sym_next;
               if (i_stop || burst_hit) begin
                  state    <= DRAIN;
                  fill_cnt <= '0;
               end
            end
            DRAIN: begin
               phase <= phase + 1'b1;
               if (strobe) begin
                  if (fill_cnt == FILL_LAST) begin
                     state    <= IDLE;
                     phase    <= '0;
                     fill_cnt <= '0;
                     done     <= 1'b1;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Enables and qualifiers are pure decodes of registered state/phase
   assign o_valid       = strobe;
   assign o_prbs_enable = (state == FILL) || (state == RUN);
   assign o_fir_enable  = (state != IDLE);
   assign o_out_valid   = strobe && ((state == RUN) || (state == DRAIN));
   assign o_busy        = (state != IDLE);
   assign o_done        = done;
   assign o_state       = state;
   assign o_sym_count   = sym_count;

endmodule

// File: tb/tb_mod_sequencer.sv
// Directed bench for mod_sequencer with default parameters
// (8-clock strobe period, 6 fill/drain symbols).
module tb_mod_sequencer;

   logic        clock;
   logic        i_reset;
   logic        i_start;
   logic        i_stop;
   logic [15:0] i_burst_len;
   logic        o_valid;
   logic        o_prbs_enable;
   logic        o_fir_enable;
   logic        o_out_valid;
   logic        o_busy;
   logic        o_done;
   logic [1:0]  o_state;
   logic [15:0] o_sym_count;

   int total = 0;
   int bad   = 0;

   int rel;
   int first_run, first_drain, done_at;
   int first_ov, last_ov;
   int n_valid, n_ov, n_done, prbs_drain;

   mod_sequencer dut (
      .clock         (clock),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_stop        (i_stop),
      .i_burst_len   (i_burst_len),
      .o_valid       (o_valid),
      .o_prbs_enable (o_prbs_enable),
      .o_fir_enable  (o_fir_enable),
      .o_out_valid   (o_out_valid),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_state       (o_state),
      .o_sym_count   (o_sym_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      rel         = 0;
      first_run   = -1;
      first_drain = -1;
      done_at     = -1;
      first_ov    = -1;
      last_ov     = -1;
      n_valid     = 0;
      n_ov        = 0;
      n_done      = 0;
      prbs_drain  = 0;
   endtask

   task automatic step1();
      @(posedge clock);
      #1;
      rel++;
      if (o_state == 2'd2 && first_run < 0) first_run = rel;
      if (o_state == 2'd3 && first_drain < 0) first_drain = rel;
      if (o_done) begin
         n_done++;
         done_at = rel;
      end
      if (o_valid) n_valid++;
      if (o_out_valid) begin
         n_ov++;
         if (first_ov < 0) first_ov = rel;
         last_ov = rel;
      end
      if (o_state == 2'd3 && o_prbs_enable) prbs_drain++;
   endtask

   task automatic run_to(input int target);
      while (rel < target) step1();
   endtask

   task automatic start_burst(input logic [15:0] len);
      i_burst_len = len;
      clear_stats();
      i_start = 1'b1;
      step1();
      i_start = 1'b0;
   endtask

   initial begin
      i_reset     = 1'b1;
      i_start     = 1'b1;
      i_stop      = 1'b0;
      i_burst_len = 16'd0;
      clear_stats();

      // reset with start held
      step1();
      step1();
      chk("rst_state", 32'(o_state), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_prbs", 32'(o_prbs_enable), 0);
      chk("rst_fir", 32'(o_fir_enable), 0);
      chk("rst_ov", 32'(o_out_valid), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_cnt", 32'(o_sym_count), 0);
      i_reset = 1'b0;
      i_start = 1'b0;
      run_to(6);
      chk("post_rst_idle", 32'(o_state), 0);

      // fixed burst of 4
      start_burst(16'd4);
      chk("b4_fill", 32'(o_state), 1);
      chk("b4_prbs", 32'(o_prbs_enable), 1);
      chk("b4_fir", 32'(o_fir_enable), 1);
      run_to(7);
      chk("b4_nv7", 32'(o_valid), 0);
      run_to(8);
      chk("b4_v8", 32'(o_valid), 1);
      chk("b4_ov8", 32'(o_out_valid), 0);
      run_to(140);
      chk("b4_run_at", 32'(first_run), 49);
      chk("b4_drain_at", 32'(first_drain), 81);
      chk("b4_done_at", 32'(done_at), 129);
      chk("b4_ndone", 32'(n_done), 1);
      chk("b4_nvalid", 32'(n_valid), 16);
      chk("b4_nov", 32'(n_ov), 10);
      chk("b4_first_ov", 32'(first_ov), 56);
      chk("b4_last_ov", 32'(last_ov), 128);
      chk("b4_prbs_drain", 32'(prbs_drain), 0);
      chk("b4_count", 32'(o_sym_count), 4);
      chk("b4_idle", 32'(o_state), 0);

      // continuous, stop after 10 strobes
      start_burst(16'd0);
      run_to(130);
      i_stop = 1'b1;
      step1();
      i_stop = 1'b0;
      chk("c_drain", 32'(o_state), 3);
      chk("c_count", 32'(o_sym_count), 10);
      run_to(190);
      chk("c_run_at", 32'(first_run), 49);
      chk("c_drain_at", 32'(first_drain), 131);
      chk("c_done_at", 32'(done_at), 177);
      chk("c_ndone", 32'(n_done), 1);
      chk("c_nov", 32'(n_ov), 16);
      chk("c_prbs_drain", 32'(prbs_drain), 0);
      chk("c_count_end", 32'(o_sym_count), 10);

      // abort in FILL
      start_burst(16'd4);
      run_to(20);
      i_stop = 1'b1;
      step1();
      i_stop = 1'b0;
      chk("f_idle", 32'(o_state), 0);
      chk("f_busy", 32'(o_busy), 0);
      chk("f_prbs", 32'(o_prbs_enable), 0);
      chk("f_fir", 32'(o_fir_enable), 0);
      chk("f_count", 32'(o_sym_count), 0);
      run_to(40);
      chk("f_ndone", 32'(n_done), 0);
      chk("f_nvalid", 32'(n_valid), 2);

      // reset in RUN
      start_burst(16'd0);
      run_to(60);
      chk("r_run", 32'(o_state), 2);
      chk("r_cnt1", 32'(o_sym_count), 1);
      i_reset = 1'b1;
      step1();
      i_reset = 1'b0;
      chk("r_idle", 32'(o_state), 0);
      chk("r_cnt0", 32'(o_sym_count), 0);
      chk("r_valid", 32'(o_valid), 0);
      run_to(75);
      chk("r_ndone", 32'(n_done), 0);
      chk("r_still_idle", 32'(o_state), 0);

      // start and stop together in IDLE
      i_start = 1'b1;
      i_stop  = 1'b1;
      step1();
      i_start = 1'b0;
      i_stop  = 1'b0;
      chk("ss_idle", 32'(o_state), 0);
      chk("ss_busy", 32'(o_busy), 0);

      // start pulse during RUN is ignored
      start_burst(16'd3);
      run_to(60);
      i_start = 1'b1;
      step1();
      i_start = 1'b0;
      chk("sr_cnt", 32'(o_sym_count), 1);
      run_to(150);
      chk("sr_drain_at", 32'(first_drain), 73);
      chk("sr_done_at", 32'(done_at), 121);
      chk("sr_ndone", 32'(n_done), 1);
      chk("sr_count", 32'(o_sym_count), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
